// File: rtl/sync_mem_pkg.sv
// Shared types and constants for the N-port synchronous scratch RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_mem_pkg;

    // Sequencer states: zero-fill after reset, then normal port service.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Read-during-write behaviour selectors.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Width of the saturating collision counter.
    localparam int COLL_CNT_W = 16;

endpackage

// File: rtl/sync_mem_wr_arb.sv
// Write arbiter: per-port grant mask, lowest port index wins on equal addresses.
// Latency: purely combinational.
// Backpressure: none; losing writes are dropped, not stalled.
//
// Ports:
//   addr_i  [NPORTS*AW]  packed per-port write addresses
//   we_i    [NPORTS]     qualified write enables (already masked by state/range)
//   grant_o [NPORTS]     write actually performed this cycle
//   coll_o               two or more enabled ports share an address
module sync_mem_wr_arb #(
    parameter int NPORTS = 3,
    parameter int AW     = 8
) (
    input  logic [NPORTS*AW-1:0] addr_i,
    input  logic [NPORTS-1:0]    we_i,
    output logic [NPORTS-1:0]    grant_o,
    output logic                 coll_o
);

    // A port loses if any lower-indexed port writes the same address.
    // Any loser implies at least two writers on one address.
    always_comb begin
        grant_o = we_i;
        coll_o  = 1'b0;
        for (int p = 1; p < NPORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (we_i[p] && we_i[q] &&
                    (addr_i[p*AW +: AW] == addr_i[q*AW +: AW])) begin
                    grant_o[p] = 1'b0;
                    coll_o     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_mem_np.sv
// N-port synchronous RAM with write priority, collision reporting and reset zero-fill.
// Latency: 1 cycle address-to-read-data; writes land on the presenting edge.
// Backpressure: none; ports are ignored while ready_o is low.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   addr_i [NPORTS*AW]      port p address at [p*AW +: AW]
//   wd_i   [NPORTS*DW]      port p write data at [p*DW +: DW]
//   we_i   [NPORTS]         port p write enable
//   rd_o   [NPORTS*DW]      port p registered read data
//   ready_o                 high once the zero-fill is finished
//   collision_o             one-cycle pulse after a same-address multi-write
//   coll_cnt_o [16]         saturating count of collision cycles
module sync_mem_np
    import sync_mem_pkg::*;
#(
    parameter int NPORTS     = 3,
    parameter int DW         = 16,
    parameter int AW         = 8,
    parameter int DEPTH      = 256,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NPORTS*AW-1:0]  addr_i,
    input  logic [NPORTS*DW-1:0]  wd_i,
    input  logic [NPORTS-1:0]     we_i,
    output logic [NPORTS*DW-1:0]  rd_o,
    output logic                  ready_o,
    output logic                  collision_o,
    output logic [COLL_CNT_W-1:0] coll_cnt_o
);

    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0]         addr_w [NPORTS];
    logic [DW-1:0]         wd_w   [NPORTS];
    logic [NPORTS-1:0]     in_rng;
    logic [NPORTS-1:0]     we_eff;
    logic [NPORTS-1:0]     grant;
    logic                  coll;

    state_t                state_q;
    logic                  ready_q;
    logic [AW-1:0]         init_cnt_q;
    logic [NPORTS*DW-1:0]  rd_q, rd_d;
    logic                  coll_q;
    logic [COLL_CNT_W-1:0] coll_cnt_q;

    logic [DW-1:0]         mem [DEPTH];

    // Out-of-range ports neither write nor count toward collisions.
    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign addr_w[g] = addr_i[g*AW +: AW];
        assign wd_w[g]   = wd_i[g*DW +: DW];
        assign in_rng[g] = ({1'b0, addr_w[g]} < DEPTH_L);
        assign we_eff[g] = (state_q == ST_RUN) && we_i[g] && in_rng[g];
    end

    sync_mem_wr_arb #(
        .NPORTS (NPORTS),
        .AW     (AW)
    ) u_wr_arb (
        .addr_i  (addr_i),
        .we_i    (we_eff),
        .grant_o (grant),
        .coll_o  (coll)
    );

    // Read path: array read gives the pre-edge word (read-old); in
    // write-through mode the winning write of the same address overrides it.
    // Granted addresses are unique, so at most one forward source matches.
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if ((state_q == ST_RUN) && in_rng[p]) begin
                rd_d[p*DW +: DW] = mem[addr_w[p]];
                if (RDW_MODE == RDW_NEW) begin
                    for (int q = 0; q < NPORTS; q++) begin
                        if (grant[q] && (addr_w[q] == addr_w[p])) begin
                            rd_d[p*DW +: DW] = wd_w[q];
                        end
                    end
                end
            end
        end
    end

    // Storage has no reset; the init sequencer clears it instead.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            mem[init_cnt_q] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (grant[p]) begin
                    mem[addr_w[p]] <= wd_w[p];
                end
            end
        end
    end

    // Sequencer plus all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            ready_q    <= 1'b0;
            init_cnt_q <= '0;
            rd_q       <= '0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    rd_q       <= '0;
                    coll_q     <= 1'b0;
                    // READY rises on the edge that clears the last word.
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                    rd_q    <= rd_d;
                    coll_q  <= coll;
                    if (coll && (coll_cnt_q != '1)) begin
                        coll_cnt_q <= coll_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign rd_o        = rd_q;
    assign ready_o     = ready_q;
    assign collision_o = coll_q;
    assign coll_cnt_o  = coll_cnt_q;

endmodule

// File: tb/tb_sync_mem_np.sv
// Self-checking bench for sync_mem_np: default 3-port read-old instance plus
// a 4-port, 40-word, write-through instance for range and saturation cases.
// Latency: n/a. Backpressure: n/a.
module tb_sync_mem_np;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [23:0]  addr = '0;
    logic [47:0]  wd = '0;
    logic [2:0]   we = '0;
    logic [47:0]  rd;
    logic         ready, coll;
    logic [15:0]  cnt;

    logic         rst2_n = 1'b0;
    logic [23:0]  addr2 = '0;
    logic [127:0] wd2 = '0;
    logic [3:0]   we2 = '0;
    logic [127:0] rd2;
    logic         ready2, coll2;
    logic [15:0]  cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_mem_np dut (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .wd_i(wd), .we_i(we),
        .rd_o(rd), .ready_o(ready), .collision_o(coll), .coll_cnt_o(cnt)
    );

    sync_mem_np #(
        .NPORTS(4), .DW(32), .AW(6), .DEPTH(40), .RDW_MODE(1), .INIT_CLEAR(1)
    ) dut2 (
        .clk_i(clk), .rst_n_i(rst2_n), .addr_i(addr2), .wd_i(wd2), .we_i(we2),
        .rd_o(rd2), .ready_o(ready2), .collision_o(coll2), .coll_cnt_o(cnt2)
    );

    typedef struct {
        logic [2:0]  we;
        logic [23:0] addr;   // {a2, a1, a0}
        logic [47:0] wd;     // {w2, w1, w0}
        logic [47:0] rd;     // expected {r2, r1, r0}
        logic        coll;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready1(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ready2(output int n);
        n = 0;
        while (!ready2 && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        vecs[0]  = '{3'b001, {8'h00,8'h00,8'h10}, {16'h0,16'h0,16'hA5A5}, 48'h0, 1'b0, 16'd0};
        vecs[1]  = '{3'b000, {8'h10,8'h00,8'h00}, 48'h0, {16'hA5A5,16'h0,16'h0}, 1'b0, 16'd0};
        vecs[2]  = '{3'b011, {8'h10,8'h20,8'h20}, {16'h0,16'h2222,16'h1111}, {16'hA5A5,16'h0,16'h0}, 1'b1, 16'd1};
        vecs[3]  = '{3'b000, {8'h20,8'h20,8'h20}, 48'h0, {16'h1111,16'h1111,16'h1111}, 1'b0, 16'd1};
        vecs[4]  = '{3'b010, {8'h10,8'h30,8'h30}, {16'h0,16'hBEEF,16'h0}, {16'hA5A5,16'h0,16'h0}, 1'b0, 16'd1};
        vecs[5]  = '{3'b000, {8'h20,8'h10,8'h30}, 48'h0, {16'h1111,16'hA5A5,16'hBEEF}, 1'b0, 16'd1};
        vecs[6]  = '{3'b111, {8'h40,8'h40,8'h40}, {16'h5555,16'h4444,16'h3333}, 48'h0, 1'b1, 16'd2};
        vecs[7]  = '{3'b111, {8'h40,8'h42,8'h41}, {16'h0003,16'h0002,16'h0001}, {16'h3333,16'h0,16'h0}, 1'b0, 16'd2};
        vecs[8]  = '{3'b000, {8'h42,8'h41,8'h40}, 48'h0, {16'h0002,16'h0001,16'h0003}, 1'b0, 16'd2};
        vecs[9]  = '{3'b110, {8'h50,8'h50,8'h50}, {16'h7777,16'h6666,16'h0}, 48'h0, 1'b1, 16'd3};
        vecs[10] = '{3'b000, {8'h50,8'h50,8'h50}, 48'h0, {16'h6666,16'h6666,16'h6666}, 1'b0, 16'd3};
        vecs[11] = '{3'b001, {8'h00,8'h00,8'h05}, {16'h0,16'h0,16'h1234}, 48'h0, 1'b0, 16'd3};
        vecs[12] = '{3'b000, {8'h05,8'h05,8'h05}, 48'h0, {16'h1234,16'h1234,16'h1234}, 1'b0, 16'd3};

        // Reset state.
        repeat (3) step();
        chk("reset_state", {rd, ready, coll, cnt}, {48'h0, 1'b0, 1'b0, 16'h0});

        // Init length and zero-filled contents.
        rst_n = 1'b1;
        wait_ready1(n);
        chk("init_cycles", n, 256);
        bad = 0;
        for (int a = 0; a < 258; a += 3) begin
            addr = {8'(a + 2), 8'(a + 1), 8'(a)};
            step();
            if (rd !== 48'h0) bad++;
        end
        chk("init_zero", bad, 0);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 13; i++) begin
            we = vecs[i].we; addr = vecs[i].addr; wd = vecs[i].wd;
            step();
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_coll", i), coll, vecs[i].coll);
            chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].cnt);
        end
        we = '0;

        // Reset mid-run: outputs clear asynchronously, memory re-cleared.
        rst_n = 1'b0;
        #2;
        chk("midrun_rst_async", {rd, ready, coll, cnt}, {48'h0, 1'b0, 1'b0, 16'h0});
        step();
        rst_n = 1'b1;
        wait_ready1(n);
        chk("midrun_reinit_cycles", n, 256);
        addr = {8'h05, 8'h05, 8'h05};
        step();
        chk("midrun_reread", rd, 48'h0);
        chk("midrun_cnt", cnt, 16'h0);

        // Reset during init restarts the fill; writes during init are ignored.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (100) step();
        chk("init_not_ready", ready, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("init_rst_async", ready, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (10) step();
        we = 3'b001; addr = {8'h00, 8'h00, 8'h05}; wd = {16'h0, 16'h0, 16'h9999};
        n = 10;
        while (!ready && n < 1000) begin
            step();
            n++;
        end
        chk("init_restart_cycles", n, 256);
        we = '0; addr = {8'h05, 8'h05, 8'h05};
        step();
        chk("init_we_ignored", rd, 48'h0);

        // Second instance: 4 ports, 32-bit, 40 words, write-through.
        rst2_n = 1'b1;
        wait_ready2(n);
        chk("p2_init_cycles", n, 40);

        we2 = 4'b0101; addr2 = {6'd0, 6'd45, 6'd45, 6'd45};
        wd2 = {32'h0, 32'hCAFEF00D, 32'h0, 32'hDEADBEEF};
        step();
        chk("p2_oor_wr_rd", rd2, 128'h0);
        chk("p2_oor_no_coll", {coll2, cnt2}, {1'b0, 16'h0});

        we2 = 4'b0000; addr2 = {6'd0, 6'd0, 6'd5, 6'd45};
        step();
        chk("p2_oor_reread", rd2, 128'h0);

        we2 = 4'b1000; addr2 = {6'd7, 6'd0, 6'd8, 6'd7};
        wd2 = {32'h12345678, 32'h0, 32'h0, 32'h0};
        step();
        chk("p2_fwd", rd2, {32'h12345678, 32'h0, 32'h0, 32'h12345678});

        we2 = 4'b0110; addr2 = {6'd7, 6'd8, 6'd8, 6'd8};
        wd2 = {32'h0, 32'hBBBB0002, 32'hAAAA0001, 32'h0};
        step();
        chk("p2_coll_fwd", rd2, {32'h12345678, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001});
        chk("p2_coll", {coll2, cnt2}, {1'b1, 16'd1});

        // Continuous collisions drive the counter into saturation.
        we2 = 4'b0011; addr2 = {6'd0, 6'd0, 6'd9, 6'd9};
        wd2 = {32'h0, 32'h0, 32'h22222222, 32'h11111111};
        repeat (65540) step();
        chk("p2_sat", {coll2, cnt2}, {1'b1, 16'hFFFF});
        we2 = 4'b0000; addr2 = {6'd0, 6'd0, 6'd0, 6'd9};
        step();
        chk("p2_sat_hold", {coll2, cnt2}, {1'b0, 16'hFFFF});
        chk("p2_sat_winner", rd2[31:0], 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
